// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN front-end blocks.
// Holds the encoder state enum and the Galois LFSR feedback masks for each supported width.
package snn_pkg;

    typedef enum logic [1:0] {
        StLoad,
        StEncode,
        StDone
    } enc_state_e;

    // Right-shifting Galois feedback masks for maximal-length sequences of 4..8 bits.
    function automatic logic [7:0] lfsr_mask(input int unsigned width);
        logic [7:0] mask;
        mask = 8'hB8;
        case (width)
            4:       mask = 8'h09;
            5:       mask = 8'h12;
            6:       mask = 8'h21;
            7:       mask = 8'h41;
            default: mask = 8'hB8;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR with a synchronous reload; reusable by other generators.
// A reload takes priority over a step in the same cycle.
module lfsr_galois #(
    parameter int unsigned      Width    = 8,
    parameter logic [Width-1:0] Mask     = Width'(8'hB8),
    parameter logic [Width-1:0] ResetVal = Width'(8'hA5)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] seed_i,
    input  logic             step_i,
    output logic [Width-1:0] state_o
);

    logic [Width-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (step_i) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? Mask : '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ResetVal;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes a frame of pixel intensities into NUM_STEPS spike vectors using a shared LFSR,
// each channel comparing against its own rotation of the LFSR state.
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 8,
    parameter int unsigned PIXEL_W      = 8,
    parameter int unsigned NUM_STEPS    = 16,
    parameter logic [7:0]  SEED         = 8'hA5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    pixel_valid_i,
    output logic                    pixel_ready_o,
    input  logic [PIXEL_W-1:0]      pixel_data_i,
    output logic                    spike_valid_o,
    input  logic                    spike_ready_i,
    output logic [NUM_CHANNELS-1:0] spike_o,
    output logic                    first_o,
    output logic                    done_o
);

    localparam int unsigned ChW   = $clog2(NUM_CHANNELS);
    localparam int unsigned StepW = $clog2(NUM_STEPS);
    localparam logic [PIXEL_W-1:0] SeedW = SEED[PIXEL_W-1:0];
    localparam logic [PIXEL_W-1:0] MaskW = PIXEL_W'(lfsr_mask(PIXEL_W));

    enc_state_e         state_q, state_d;
    logic [ChW-1:0]     ch_idx_q, ch_idx_d;
    logic [StepW-1:0]   step_q, step_d;
    logic [PIXEL_W-1:0] pix_q [NUM_CHANNELS];
    logic               ready_q, ready_d;
    logic [PIXEL_W-1:0] lfsr;
    logic [NUM_CHANNELS-1:0] spike_raw;

    logic pix_xfer, last_pix, beat_acc, last_beat;

    assign pix_xfer  = pixel_valid_i & ready_q;
    assign last_pix  = pix_xfer && (ch_idx_q == ChW'(NUM_CHANNELS - 1));
    assign beat_acc  = (state_q == StEncode) && spike_ready_i;
    assign last_beat = beat_acc && (step_q == StepW'(NUM_STEPS - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad:   if (last_pix) state_d = StEncode;
            StEncode: if (last_beat) state_d = StDone;
            StDone:   state_d = StLoad;
            default:  state_d = StLoad;
        endcase
    end

    always_comb begin
        spike_valid_o = (state_q == StEncode);
        done_o        = (state_q == StDone);
        first_o       = spike_valid_o && (step_q == '0);
        spike_o       = spike_valid_o ? spike_raw : '0;
        pixel_ready_o = ready_q;
    end

    always_comb begin
        ready_d  = (state_d == StLoad);
        ch_idx_d = ch_idx_q;
        if (last_pix) begin
            ch_idx_d = '0;
        end else if (pix_xfer) begin
            ch_idx_d = ch_idx_q + 1'b1;
        end
        step_d = step_q;
        if (state_q != StEncode) begin
            step_d = '0;
        end else if (beat_acc) begin
            step_d = step_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ch_idx_q <= '0;
            step_q   <= '0;
            ready_q  <= 1'b0;
            for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
                pix_q[i] <= '0;
            end
        end else begin
            ch_idx_q <= ch_idx_d;
            step_q   <= step_d;
            ready_q  <= ready_d;
            if (pix_xfer) begin
                pix_q[ch_idx_q] <= pixel_data_i;
            end
        end
    end

    // Reloaded on every frame start so each frame sees the same threshold sequence.
    lfsr_galois #(
        .Width    (PIXEL_W),
        .Mask     (MaskW),
        .ResetVal (SeedW)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (last_pix),
        .seed_i  (SeedW),
        .step_i  (beat_acc),
        .state_o (lfsr)
    );

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_cmp
        logic [PIXEL_W-1:0] rot;
        assign rot          = (lfsr << c) | (lfsr >> (PIXEL_W - c));
        assign spike_raw[c] = (pix_q[c] >= rot);
    end

endmodule
